// File: rtl/pixel_alu_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_alu_sequencer_if
//  Purpose  : Bundles the pixel RAM read/write ports and the combinational
//             ALU operand/result lines that connect the sequencer to its
//             datapath.
//  Ports    : master modport (sequencer side)
//               out mem_rd_en, mem_rd_addr  -- pixel RAM read strobe/address
//               in  mem_rd_data             -- read data, 1 cycle after strobe
//               out alu_a, alu_b, alu_fun   -- ALU operands and function
//               in  alu_out                 -- ALU result (combinational)
//               out mem_wr_en, mem_wr_addr, mem_wr_data -- pixel RAM write
//             slave modport is the mirror image (RAM / ALU side).
//  Revision : 1.0  initial release
// ============================================================================
interface pixel_alu_sequencer_if #(
  parameter int ADDR_W = 16
) ();
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [7:0]        mem_rd_data;
  logic [7:0]        alu_a;
  logic [7:0]        alu_b;
  logic [2:0]        alu_fun;
  logic [7:0]        alu_out;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [7:0]        mem_wr_data;

  modport master (
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_data,
    output alu_a, alu_b, alu_fun,
    input  alu_out,
    output mem_wr_en, mem_wr_addr, mem_wr_data
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_data,
    input  alu_a, alu_b, alu_fun,
    output alu_out,
    input  mem_wr_en, mem_wr_addr, mem_wr_data
  );
endinterface
`default_nettype wire

// File: rtl/pixel_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_alu_sequencer
//  Purpose  : Walks a block of LEN pixels from SRC_BASE through the external
//             combinational 8-bit ALU with a key operand and writes each
//             result to DST_BASE, one pixel every 4 cycles
//             (RD -> WAIT -> EXEC -> WR).
//  Ports    : clk, rst_n          -- clock, asynchronous active-low reset
//             start, abort        -- job launch pulse / job cancel
//             cfg_fun/key/src/dst/len -- job configuration, latched on start
//             bus (master)        -- pixel RAM and ALU connections
//             busy, done, aborted -- job status
//  Options  : PIXEL_SEQ_KEY_ROTATE_EN -- when defined, the working key rotates
//             left by one bit after every pixel write.
//  Revision : 1.0  initial release
// ============================================================================
module pixel_alu_sequencer #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              start,
  input  wire logic              abort,
  input  wire logic [2:0]        cfg_fun,
  input  wire logic [7:0]        cfg_key,
  input  wire logic [ADDR_W-1:0] cfg_src,
  input  wire logic [ADDR_W-1:0] cfg_dst,
  input  wire logic [LEN_W-1:0]  cfg_len,
  pixel_alu_sequencer_if.master  bus,
  output      logic              busy,
  output      logic              done,
  output      logic              aborted
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_EXEC = 3'd3,
    ST_WR   = 3'd4,
    ST_FIN  = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [2:0]        r_fun;
  logic [7:0]        r_key;       // working key (rotates when the option is on)
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_idx;
  logic [7:0]        r_result;
  logic [7:0]        r_alu_a;     // doubles as the pixel register
  logic [7:0]        r_alu_b;
  logic [2:0]        r_alu_fun;
  logic              r_aborted;

  logic              w_busy;
  logic              w_accept;
  logic              w_last;
  logic [7:0]        w_operand_b;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_wr_addr;

  // FIN is deliberately not part of busy: busy falls as done rises.
  assign w_busy   = (r_state == ST_RD) || (r_state == ST_WAIT) ||
                    (r_state == ST_EXEC) || (r_state == ST_WR);
  // abort takes priority over a start seen in the same IDLE cycle.
  assign w_accept = (r_state == ST_IDLE) && start && !abort;
  assign w_last   = ((r_idx + LEN_W'(1)) == r_len);

  // Shift-type functions only use the low three key bits as the amount.
  assign w_operand_b = (r_fun >= 3'd4) ? {5'b0, r_key[2:0]} : r_key;

  // Address sums wrap naturally at ADDR_W bits.
  assign w_rd_addr = r_src + ADDR_W'(r_idx);
  assign w_wr_addr = r_dst + ADDR_W'(r_idx);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = (cfg_len == '0) ? ST_FIN : ST_RD;
        end
      end
      ST_RD:   w_state_next = ST_WAIT;
      ST_WAIT: w_state_next = ST_EXEC;
      ST_EXEC: w_state_next = ST_WR;
      ST_WR:   w_state_next = w_last ? ST_FIN : ST_RD;
      ST_FIN:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
    if (w_busy && abort) begin
      w_state_next = ST_IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fun     <= '0;
      r_key     <= '0;
      r_src     <= '0;
      r_dst     <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_result  <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_fun <= '0;
      r_aborted <= 1'b0;
    end else begin
      r_aborted <= w_busy && abort;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_fun <= cfg_fun;
            r_key <= cfg_key;
            r_src <= cfg_src;
            r_dst <= cfg_dst;
            r_len <= cfg_len;
            r_idx <= '0;
          end
        end
        ST_WAIT: begin
          // Loading here presents the operands for the whole EXEC cycle; an
          // abort suppresses the load so the ALU lines keep their old values.
          if (!abort) begin
            r_alu_a   <= bus.mem_rd_data;
            r_alu_b   <= w_operand_b;
            r_alu_fun <= r_fun;
          end
        end
        ST_EXEC: begin
          r_result <= (r_fun == 3'd0) ? r_alu_a : bus.alu_out;
        end
        ST_WR: begin
          r_idx <= r_idx + LEN_W'(1);
`ifdef PIXEL_SEQ_KEY_ROTATE_EN
          r_key <= {r_key[6:0], r_key[7]};
`endif
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: strobes decode straight from the state so an asynchronous reset
  // removes them immediately; addresses/data are zeroed outside their strobe.
  // --------------------------------------------------------------------------
  assign bus.mem_rd_en   = (r_state == ST_RD);
  assign bus.mem_rd_addr = (r_state == ST_RD) ? w_rd_addr : '0;
  assign bus.mem_wr_en   = (r_state == ST_WR);
  assign bus.mem_wr_addr = (r_state == ST_WR) ? w_wr_addr : '0;
  assign bus.mem_wr_data = (r_state == ST_WR) ? r_result  : '0;
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alu_fun     = r_alu_fun;

  assign busy    = w_busy;
  assign done    = (r_state == ST_FIN);
  assign aborted = r_aborted;

endmodule
`default_nettype wire

// File: tb/tb_pixel_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pixel_alu_sequencer
//  Purpose  : Self-checking bench for pixel_alu_sequencer. Provides a pixel
//             RAM and an 8-bit ALU, runs directed and random jobs and checks
//             memory traffic, latency and status pulses against a per-pixel
//             reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pixel_alu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [2:0]  cfg_fun;
  logic [7:0]  cfg_key;
  logic [15:0] cfg_src;
  logic [15:0] cfg_dst;
  logic [15:0] cfg_len;
  logic        busy;
  logic        done;
  logic        aborted;

  int n_checks;
  int n_errors;

  logic [7:0] ram [0:65535];

  pixel_alu_sequencer_if #(.ADDR_W(16)) bus ();

  pixel_alu_sequencer #(.ADDR_W(16), .LEN_W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .cfg_fun (cfg_fun),
    .cfg_key (cfg_key),
    .cfg_src (cfg_src),
    .cfg_dst (cfg_dst),
    .cfg_len (cfg_len),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .aborted (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: 1 end-around-carry add, 2 xnor, 3 xor, 4 shl, 5 shr,
  // 6 ror, 7 rol; 0 passes A.
  function automatic logic [7:0] alu_ref(input logic [2:0] f, input logic [7:0] a,
                                         input logic [7:0] b);
    logic [8:0]  s;
    logic [15:0] t;
    case (f)
      3'd1: begin s = {1'b0, a} + {1'b0, b}; alu_ref = s[7:0] + {7'b0, s[8]}; end
      3'd2: alu_ref = ~(a ^ b);
      3'd3: alu_ref = a ^ b;
      3'd4: alu_ref = a << b[2:0];
      3'd5: alu_ref = a >> b[2:0];
      3'd6: begin t = {a, a} >> b[2:0]; alu_ref = t[7:0]; end
      3'd7: begin t = {a, a} << b[2:0]; alu_ref = t[15:8]; end
      default: alu_ref = a;
    endcase
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << (n % 8);
    return t[15:8];
  endfunction

  always_comb bus.alu_out = alu_ref(bus.alu_fun, bus.alu_a, bus.alu_b);

  // Pixel RAM: read data appears one cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= ram[bus.mem_rd_addr];
    else               bus.mem_rd_data <= 8'($urandom);
    if (bus.mem_wr_en) ram[bus.mem_wr_addr] = bus.mem_wr_data;
  end

  logic [63:0] w_outs;
  assign w_outs = {21'b0, busy, done, aborted, bus.mem_rd_en, bus.mem_wr_en,
                   bus.mem_rd_addr, bus.mem_wr_addr, bus.mem_wr_data,
                   bus.alu_a, bus.alu_b, bus.alu_fun};

  task automatic check_value(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one job starting at the current negedge. abort_at>0 asserts abort
  // during that cycle of the job; restart pulses a second start in cycle 2.
  task automatic run_job(input logic [2:0] f, input logic [7:0] k,
                         input logic [15:0] s, input logic [15:0] d,
                         input logic [15:0] n, input int abort_at, input bit restart);
    logic [15:0] exp_ra[$];
    logic [15:0] exp_wa[$];
    logic [7:0]  exp_wd[$];
    logic [15:0] got_ra[$];
    logic [15:0] got_wa[$];
    logic [7:0]  got_wd[$];
    logic [7:0]  shadow[int];
    logic [15:0] a;
    logic [7:0]  pix, kk, b, r;
    int          busy_cycles, end_cycle, limit, cyc;
    bit          seen_end, end_done, end_ab;

    // Reference model: pixels in order, each read before it is written.
    for (int i = 0; i < int'(n); i++) begin
      a   = s + 16'(i);
      pix = shadow.exists(int'(a)) ? shadow[int'(a)] : ram[a];
`ifdef PIXEL_SEQ_KEY_ROTATE_EN
      kk  = rol8(k, i);
`else
      kk  = k;
`endif
      b   = (f >= 3'd4) ? {5'b0, kk[2:0]} : kk;
      r   = (f == 3'd0) ? pix : alu_ref(f, pix, b);
      if (abort_at == 0 || 4 * i + 1 <= abort_at) exp_ra.push_back(a);
      if (abort_at == 0 || 4 * i + 4 <= abort_at) begin
        exp_wa.push_back(d + 16'(i));
        exp_wd.push_back(r);
        shadow[int'(d + 16'(i))] = r;
      end
    end

    cfg_fun = f; cfg_key = k; cfg_src = s; cfg_dst = d; cfg_len = n;
    start = 1'b1;
    @(negedge clk);
    busy_cycles = 0; end_cycle = 0; seen_end = 0; end_done = 0; end_ab = 0;
    limit = 4 * int'(n) + 8;
    for (cyc = 1; cyc <= limit; cyc++) begin
      if (bus.mem_rd_en) got_ra.push_back(bus.mem_rd_addr);
      if (bus.mem_wr_en) begin
        got_wa.push_back(bus.mem_wr_addr);
        got_wd.push_back(bus.mem_wr_data);
      end
      if (busy) busy_cycles++;
      if (done || aborted) begin
        seen_end = 1; end_cycle = cyc; end_done = done; end_ab = aborted;
        break;
      end
      // Scramble config after acceptance: the job must use latched values.
      cfg_fun = 3'($urandom); cfg_key = 8'($urandom);
      cfg_src = 16'($urandom); cfg_dst = 16'($urandom); cfg_len = 16'($urandom_range(1, 9));
      start = restart && (cyc == 2);
      abort = (cyc == abort_at);
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;

    check_value("job_end_seen", 64'(seen_end), 64'd1);
    if (abort_at != 0) begin
      check_value("aborted_pulse", 64'(end_ab), 64'd1);
      check_value("done_on_abort", 64'(end_done), 64'd0);
      check_value("abort_cycle", 64'(end_cycle), 64'(abort_at + 1));
      check_value("busy_cycles_abort", 64'(busy_cycles), 64'(abort_at));
    end else begin
      check_value("done_pulse", 64'(end_done), 64'd1);
      check_value("aborted_on_done", 64'(end_ab), 64'd0);
      check_value("done_latency", 64'(end_cycle), 64'(4 * int'(n) + 1));
      check_value("busy_cycles", 64'(busy_cycles), 64'(4 * int'(n)));
    end
    check_value("read_count", 64'(got_ra.size()), 64'(exp_ra.size()));
    check_value("write_count", 64'(got_wa.size()), 64'(exp_wa.size()));
    for (int i = 0; i < exp_ra.size() && i < got_ra.size(); i++)
      check_value($sformatf("rd_addr[%0d]", i), 64'(got_ra[i]), 64'(exp_ra[i]));
    for (int i = 0; i < exp_wa.size() && i < got_wa.size(); i++) begin
      check_value($sformatf("wr_addr[%0d]", i), 64'(got_wa[i]), 64'(exp_wa[i]));
      check_value($sformatf("wr_data[%0d]", i), 64'(got_wd[i]), 64'(exp_wd[i]));
    end
    @(negedge clk);
    check_value("status_clear", {61'b0, busy, done, aborted}, 64'd0);
  endtask

  logic [2:0]  rf;
  logic [7:0]  rk;
  logic [15:0] rs, rd, rn;
  int          rab;
  logic [7:0]  exp6;

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_fun = '0; cfg_key = '0; cfg_src = '0; cfg_dst = '0; cfg_len = '0;
    repeat (3) @(negedge clk);
    check_value("reset_outputs", w_outs, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_value("idle_after_reset", w_outs, 64'd0);

    // Example job: end-around add over three pixels.
    ram[16'h0100] = 8'h05; ram[16'h0101] = 8'hF8; ram[16'h0102] = 8'h20;
    run_job(3'd1, 8'h10, 16'h0100, 16'h0200, 16'd3, 0, 0);
    check_value("ram_200", 64'(ram[16'h0200]), 64'h15);
    check_value("ram_201", 64'(ram[16'h0201]), 64'h09);
    check_value("ram_202", 64'(ram[16'h0202]), 64'h30);

    // xnor and rotate-left with the low key bits.
    ram[16'h0400] = 8'h10;
    run_job(3'd2, 8'h30, 16'h0400, 16'h0500, 16'd1, 0, 0);
    check_value("ram_xnor", 64'(ram[16'h0500]), 64'hDF);
    ram[16'h0410] = 8'h81;
    run_job(3'd7, 8'h0B, 16'h0410, 16'h0510, 16'd1, 0, 0);
    check_value("ram_rol", 64'(ram[16'h0510]), 64'h0C);

    // Zero-length job, then a start ignored while busy.
    run_job(3'd3, 8'h55, 16'h0600, 16'h0700, 16'd0, 0, 0);
    run_job(3'd3, 8'h55, 16'h0600, 16'h0700, 16'd3, 0, 1);

    // Address wrap, then the same with abort in the second RD.
    run_job(3'd3, 8'hA5, 16'hFFFF, 16'hFFFE, 16'd2, 0, 0);
    run_job(3'd3, 8'hA5, 16'hFFFF, 16'hFFFE, 16'd2, 5, 0);

    // Key rotation option.
    ram[16'h0800] = 8'h00; ram[16'h0801] = 8'h00;
    run_job(3'd3, 8'h81, 16'h0800, 16'h0900, 16'd2, 0, 0);
`ifdef PIXEL_SEQ_KEY_ROTATE_EN
    exp6 = 8'h03;
`else
    exp6 = 8'h81;
`endif
    check_value("ram_key0", 64'(ram[16'h0900]), 64'h81);
    check_value("ram_key1", 64'(ram[16'h0901]), 64'(exp6));

    // abort alone in IDLE, then start+abort together in IDLE.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_value("idle_abort_no_pulse", {62'b0, aborted, busy}, 64'd0);
    cfg_len = 16'd2; cfg_src = 16'h0A00; cfg_dst = 16'h0B00;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_value("start_abort_busy", {63'b0, busy}, 64'd0);
    @(negedge clk);
    check_value("start_abort_quiet", {61'b0, done, aborted, bus.mem_rd_en}, 64'd0);

    // Asynchronous reset while in EXEC.
    ram[16'h0C00] = 8'hA5;
    cfg_fun = 3'd3; cfg_key = 8'h5A; cfg_src = 16'h0C00; cfg_dst = 16'h0D00; cfg_len = 16'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_value("exec_alu_a", 64'(bus.alu_a), 64'hA5);
    #1 rst_n = 1'b0;
    #1 check_value("async_reset_outputs", w_outs, 64'd0);
    repeat (2) @(negedge clk);
    check_value("reset_no_pulse", {62'b0, done, aborted}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_job(3'd1, 8'h22, 16'h0C00, 16'h0C00, 16'd4, 0, 0);

    // Random jobs, including overlapping and in-place buffers and aborts.
    for (int j = 0; j < 24; j++) begin
      rf = 3'($urandom);
      rk = 8'($urandom);
      rs = 16'($urandom);
      rn = 16'($urandom_range(0, 6));
      case ($urandom_range(0, 2))
        0:       rd = rs;
        1:       rd = rs + 16'($urandom_range(1, 4));
        default: rd = 16'($urandom);
      endcase
      rab = (rn != 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4 * int'(rn))) : 0;
      run_job(rf, rk, rs, rd, rn, rab, (rn > 1) && ($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
